matrix_loader: RTL and testbench
================================

Name: matrix_loader

Overview:
Upstream write-side stage for the matrix operand memory. It accepts a stream of matrix elements over a valid/ready handshake and writes them into the memory's write port. Elements arrive in row-major order; the block can store them row-major or transposed, so the multiplier's read side always sees the layout it needs. A start/done pair frames each matrix load.

Parameters:
DATA_SIZE, 8, element width in bits; must match the memory's DATA_SIZE
ROWS, 4, rows of the incoming matrix (>=1)
COLS, 4, columns of the incoming matrix (>=1)
DEPTH, ROWS*COLS, target memory depth; must equal ROWS*COLS
AW, $clog2(DEPTH), write address width (localparam)

Ports:
clk  in  1  clock; also drives the memory write clock
rst_n  in  1  asynchronous active-low reset
start_i  in  1  begin a load; sampled only in IDLE
transpose_i  in  1  layout select, sampled together with start_i: 0 = row-major, 1 = transposed
s_data_i  in  DATA_SIZE  streamed element
s_valid_i  in  1  s_data_i is valid
s_ready_o  out  1  block accepts an element this cycle
w_addr_o  out  AW  memory write address
w_data_o  out  DATA_SIZE  memory write data
w_en_o  out  1  memory write enable
busy_o  out  1  high from start acceptance until done
done_o  out  1  one-cycle pulse after the last write has been issued

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; row_cnt=0 and col_cnt=0; transpose register=0. All outputs are 0: s_ready_o, w_addr_o, w_data_o, w_en_o, busy_o, done_o. Memory contents are not touched.
- FSM states are IDLE, LOAD and DONE.
- IDLE: s_ready_o=0 and busy_o=0.
  - On start_i=1: latch transpose_i, clear both counters, go to LOAD.
- LOAD: s_ready_o=1 and busy_o=1.
  - Handshake occurs when s_valid_i && s_ready_o.
  - On a handshake, the next clock edge registers the write: w_en_o<=1 and w_data_o<=s_data_i.
  - Write address is row_cnt*COLS+col_cnt when transpose=0, and col_cnt*ROWS+row_cnt when transpose=1.
  - Latency is exactly 1 cycle from the handshake edge to w_en_o high. The memory captures the data on the following clk edge.
  - With no handshake, w_en_o<=0 and w_addr_o/w_data_o hold their values.
  - A gap in s_valid_i stalls the load without any penalty.
- Counters:
  - col_cnt increments on each handshake.
  - At COLS-1, col_cnt wraps to 0 and row_cnt increments.
  - A handshake at row_cnt=ROWS-1 and col_cnt=COLS-1 is the last element: go to DONE. s_ready_o drops in the very next cycle, so no extra element is accepted.
- DONE (1 cycle): busy_o=1 and done_o=1. This is the same cycle in which w_en_o=1 for the last element. Then return to IDLE.
- In the cycle after DONE, w_en_o=0 and busy_o=0.
- start_i while in LOAD or DONE is ignored. No queuing.
- Back-to-back loads: start_i may be asserted in the first IDLE cycle after DONE.
- s_valid_i while not in LOAD: no handshake, no write.
- Degenerate sizes:
  - ROWS=1 or COLS=1: counter widths are max(1,$clog2(N)).
  - ROWS=COLS=1: a single handshake goes straight to DONE.
- Arithmetic: address products are computed in AW bits. They are never out of range because DEPTH=ROWS*COLS.
- Reset in the middle of a load aborts it immediately. A partially written matrix is left in memory, and done_o is never emitted for that load.

Decomposition:
- Package mm_pkg:
  - typedef enum for loader_state_t (IDLE, LOAD, DONE).
  - Function for the row-major/transposed address computation, shared with the future read-side address generator.
  - Default DATA_SIZE, ROWS and COLS constants.
- Sub-module: none. The counters and FSM are small enough to stay flat.
- Integration: the top level instantiates matrix_loader feeding memory.
  - w_clk is connected to clk.
  - w_addr_o, w_data_o and w_en_o connect to w_addr_i, w_data_i and w_en_i.

Test Plan:
- ROWS=2, COLS=3, transpose=0. Start, then stream 10,11,12,13,14,15 with valid held high → writes to addresses 0,1,2,3,4,5. done_o pulses in the cycle of the address-5 write. The memory read port shows mem[4]=14.
- Same stream with transpose=1 → write addresses 0,2,4,1,3,5. The memory read port shows mem[2]=11 and mem[3]=14.
- Valid gaps: deassert s_valid_i for 3 cycles after element 2 → w_en_o=0 during the gap, no address advance, and the final memory image is identical to the first scenario.
- Reset mid-load: assert rst_n=0 after 3 handshakes → w_en_o, busy_o and s_ready_o go to 0 asynchronously and no done_o follows. A new start reloads from address 0.
- Protocol edges:
  - start_i pulsed during LOAD → ignored, counters unchanged.
  - s_valid_i high in IDLE → no write.
  - s_valid_i held high after the last element → s_ready_o=0 and exactly 6 writes total.
- Back-to-back: start_i in the first IDLE cycle after done_o → the second load begins with no lost cycle and writes to address 0 first.

Source files
------------

// File: rtl/mm_pkg.sv
// Shared types and helpers for the matrix operand memory path (loader now, read-side later).
// Holds the loader FSM encoding, default geometry and the element address mapping.
package mm_pkg;

   localparam int MmDataSize = 8;
   localparam int MmRows     = 4;
   localparam int MmCols     = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } loader_state_t;

   // Linear memory index of element (row, col) of a rows x cols matrix,
   // stored row-major or transposed (column-major).
   function automatic int unsigned mm_elem_addr(input int unsigned row,
                                                input int unsigned col,
                                                input int unsigned rows,
                                                input int unsigned cols,
                                                input logic        transpose);
      if (transpose) begin
         return col * rows + row;
      end
      return row * cols + col;
   endfunction

endpackage

// File: rtl/matrix_loader.sv
// Streams row-major matrix elements into the operand memory write port,
// optionally transposing the layout; start/done frame each matrix load.
module matrix_loader
   import mm_pkg::*;
#(
   parameter int DATA_SIZE = MmDataSize,
   parameter int ROWS      = MmRows,
   parameter int COLS      = MmCols,
   parameter int DEPTH     = ROWS * COLS,
   localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_i,
   input  logic                 transpose_i,
   input  logic [DATA_SIZE-1:0] s_data_i,
   input  logic                 s_valid_i,
   output logic                 s_ready_o,
   output logic [AW-1:0]        w_addr_o,
   output logic [DATA_SIZE-1:0] w_data_o,
   output logic                 w_en_o,
   output logic                 busy_o,
   output logic                 done_o
);

   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

   loader_state_t        r_state, w_state_d;
   logic [RW-1:0]        r_row_cnt, w_row_cnt_d;
   logic [CW-1:0]        r_col_cnt, w_col_cnt_d;
   logic                 r_transpose, w_transpose_d;
   logic [AW-1:0]        r_w_addr, w_w_addr_d;
   logic [DATA_SIZE-1:0] r_w_data, w_w_data_d;
   logic                 r_w_en, w_w_en_d;
   logic                 w_handshake;
   logic                 w_last_col;
   logic                 w_last_row;

   assign w_handshake = (r_state == LOAD) && s_valid_i;
   assign w_last_col  = (r_col_cnt == CW'(COLS - 1));
   assign w_last_row  = (r_row_cnt == RW'(ROWS - 1));

   always_comb begin
      w_state_d     = r_state;
      w_row_cnt_d   = r_row_cnt;
      w_col_cnt_d   = r_col_cnt;
      w_transpose_d = r_transpose;
      w_w_addr_d    = r_w_addr;
      w_w_data_d    = r_w_data;
      w_w_en_d      = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (start_i) begin
               w_state_d     = LOAD;
               w_transpose_d = transpose_i;
               w_row_cnt_d   = '0;
               w_col_cnt_d   = '0;
            end
         end
         LOAD: begin
            if (w_handshake) begin
               w_w_en_d   = 1'b1;
               w_w_data_d = s_data_i;
               w_w_addr_d = AW'(mm_elem_addr(32'(r_row_cnt), 32'(r_col_cnt),
                                             32'(ROWS), 32'(COLS), r_transpose));
               if (w_last_col) begin
                  w_col_cnt_d = '0;
                  if (w_last_row) begin
                     w_row_cnt_d = '0;
                     w_state_d   = DONE;
                  end else begin
                     w_row_cnt_d = r_row_cnt + 1'b1;
                  end
               end else begin
                  w_col_cnt_d = r_col_cnt + 1'b1;
               end
            end
         end
         DONE:    w_state_d = IDLE;
         default: w_state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_row_cnt   <= '0;
         r_col_cnt   <= '0;
         r_transpose <= 1'b0;
         r_w_addr    <= '0;
         r_w_data    <= '0;
         r_w_en      <= 1'b0;
      end else begin
         r_state     <= w_state_d;
         r_row_cnt   <= w_row_cnt_d;
         r_col_cnt   <= w_col_cnt_d;
         r_transpose <= w_transpose_d;
         r_w_addr    <= w_w_addr_d;
         r_w_data    <= w_w_data_d;
         r_w_en      <= w_w_en_d;
      end
   end

   // Handshake signals come straight from state so reset clears them asynchronously.
   assign s_ready_o = (r_state == LOAD);
   assign busy_o    = (r_state != IDLE);
   assign done_o    = (r_state == DONE);
   assign w_addr_o  = r_w_addr;
   assign w_data_o  = r_w_data;
   assign w_en_o    = r_w_en;

endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for matrix_loader (2x3 matrix) with a behavioural memory on the write port.
module tb_matrix_loader;

   localparam int DS = 8;
   localparam int R  = 2;
   localparam int C  = 3;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start_i = 1'b0;
   logic          transpose_i = 1'b0;
   logic [DS-1:0] s_data_i = '0;
   logic          s_valid_i = 1'b0;
   logic          s_ready_o;
   logic [AW-1:0] w_addr_o;
   logic [DS-1:0] w_data_o;
   logic          w_en_o;
   logic          busy_o;
   logic          done_o;

   int n_vec = 0;
   int n_err = 0;
   int wr_cnt = 0;
   int done_cnt = 0;
   logic [DS-1:0] mem [R*C];

   matrix_loader #(.DATA_SIZE(DS), .ROWS(R), .COLS(C)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start_i),
      .transpose_i (transpose_i),
      .s_data_i    (s_data_i),
      .s_valid_i   (s_valid_i),
      .s_ready_o   (s_ready_o),
      .w_addr_o    (w_addr_o),
      .w_data_o    (w_data_o),
      .w_en_o      (w_en_o),
      .busy_o      (busy_o),
      .done_o      (done_o)
   );

   always #5 clk = ~clk;

   // Behavioural memory: captures on the edge where w_en_o is high.
   always @(posedge clk) begin
      if (w_en_o) begin
         mem[w_addr_o] <= w_data_o;
         wr_cnt = wr_cnt + 1;
      end
      if (done_o) done_cnt = done_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full load: start, six elements 10..15, optional 3-cycle gap after
   // element gap_after, optional start pulse mid-load, optional valid held at end.
   task automatic run_load(input logic tr, input int gap_after, input logic start_mid,
                           input logic hold_valid);
      int exp_addr;
      int wr0;
      wr0 = wr_cnt;
      start_i = 1'b1;
      transpose_i = tr;
      step();
      start_i = 1'b0;
      transpose_i = ~tr;
      chk("load_busy", 32'(busy_o), 32'd1);
      chk("load_ready", 32'(s_ready_o), 32'd1);
      for (int i = 0; i < R*C; i++) begin
         if (i == gap_after) begin
            s_valid_i = 1'b0;
            for (int g = 0; g < 3; g++) begin
               step();
               chk("gap_wen", 32'(w_en_o), 32'd0);
               chk("gap_addr_hold", 32'(w_addr_o), 32'(exp_addr));
            end
         end
         exp_addr = tr ? ((i % C) * R + (i / C)) : i;
         s_data_i = DS'(10 + i);
         s_valid_i = 1'b1;
         start_i = (start_mid && i == 2);
         step();
         start_i = 1'b0;
         chk("wr_en", 32'(w_en_o), 32'd1);
         chk("wr_addr", 32'(w_addr_o), 32'(exp_addr));
         chk("wr_data", 32'(w_data_o), 32'(10 + i));
         chk("done_timing", 32'(done_o), (i == R*C-1) ? 32'd1 : 32'd0);
      end
      chk("ready_after_last", 32'(s_ready_o), 32'd0);
      s_data_i = 8'hEE;
      s_valid_i = hold_valid;
      step();
      chk("post_done", 32'(done_o), 32'd0);
      chk("post_busy", 32'(busy_o), 32'd0);
      chk("post_wen", 32'(w_en_o), 32'd0);
      if (hold_valid) begin
         step();
         chk("hold_valid_wen", 32'(w_en_o), 32'd0);
      end
      s_valid_i = 1'b0;
      chk("writes_per_load", 32'(wr_cnt - wr0), 32'(R*C));
   endtask

   initial begin
      int d0;
      int w0;
      #3;
      chk("rst_ready", 32'(s_ready_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_wen", 32'(w_en_o), 32'd0);
      chk("rst_addr", 32'(w_addr_o), 32'd0);
      chk("rst_data", 32'(w_data_o), 32'd0);
      #10 rst_n = 1'b1;
      step();

      // Valid in IDLE must not write.
      w0 = wr_cnt;
      s_valid_i = 1'b1;
      s_data_i = 8'h55;
      repeat (3) step();
      s_valid_i = 1'b0;
      step();
      chk("idle_valid_nowrite", 32'(wr_cnt - w0), 32'd0);

      run_load(1'b0, -1, 1'b0, 1'b0);
      for (int a = 0; a < R*C; a++) chk("rowmajor_img", 32'(mem[a]), 32'(10 + a));
      chk("rowmajor_mem4", 32'(mem[4]), 32'd14);

      // Back-to-back, transposed.
      run_load(1'b1, -1, 1'b0, 1'b0);
      chk("tr_mem2", 32'(mem[2]), 32'd11);
      chk("tr_mem3", 32'(mem[3]), 32'd14);
      chk("tr_mem1", 32'(mem[1]), 32'd13);

      // Gap after element 2 and a start pulse mid-load; image must match row-major.
      run_load(1'b0, 3, 1'b1, 1'b0);
      for (int a = 0; a < R*C; a++) chk("gap_img", 32'(mem[a]), 32'(10 + a));

      // Valid held after the last element.
      run_load(1'b1, -1, 1'b0, 1'b1);

      // Reset mid-load after 3 handshakes.
      step();
      d0 = done_cnt;
      start_i = 1'b1;
      transpose_i = 1'b0;
      step();
      start_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         s_data_i = DS'(40 + i);
         s_valid_i = 1'b1;
         step();
      end
      s_valid_i = 1'b0;
      chk("pre_rst_wen", 32'(w_en_o), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_wen", 32'(w_en_o), 32'd0);
      chk("async_rst_busy", 32'(busy_o), 32'd0);
      chk("async_rst_ready", 32'(s_ready_o), 32'd0);
      step();
      #2 rst_n = 1'b1;
      repeat (3) step();
      chk("no_done_after_rst", 32'(done_cnt - d0), 32'd0);

      // Reload after abort starts from address 0.
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      s_data_i = 8'h77;
      s_valid_i = 1'b1;
      step();
      s_valid_i = 1'b0;
      chk("reload_addr", 32'(w_addr_o), 32'd0);
      chk("reload_data", 32'(w_data_o), 32'h77);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end

endmodule
